// File: rtl/led_sequencer.sv
// LED pattern scheduler: prescaled step tick, IDLE/RUN/PAUSE control,
// four selectable patterns on LED1..LED4 and a heartbeat on LED5.
module led_sequencer #(
   parameter int TICK_DIV = 6_000_000
) (
   input  logic       SYS_CLK,
   input  logic       RST,
   input  logic [1:0] MODE,
   input  logic       START,
   input  logic       STOP,
   output logic       BUSY,
   output logic       LED1,
   output logic       LED2,
   output logic       LED3,
   output logic       LED4,
   output logic       LED5
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state, state_n;
   logic [PW-1:0] presc, presc_n;
   logic [3:0]    pat, pat_n;
   logic          dir_dn, dir_dn_n;
   logic          hb, hb_n;
   logic [1:0]    mode_q, mode_n;
   logic          busy_q;

   function automatic logic [3:0] init_pat(input logic [1:0] m);
      return (m == 2'b01 || m == 2'b10) ? 4'b0001 : 4'b0000;
   endfunction

   always_comb begin
      state_n  = state;
      presc_n  = presc;
      pat_n    = pat;
      dir_dn_n = dir_dn;
      hb_n     = hb;
      mode_n   = mode_q;
      unique case (state)
         IDLE: begin
            presc_n  = '0;
            pat_n    = 4'b0000;
            dir_dn_n = 1'b0;
            hb_n     = 1'b0;
            // STOP outranks START even here, so both high keeps IDLE
            if (START && !STOP) begin
               state_n = RUN;
               mode_n  = MODE;
               pat_n   = init_pat(MODE);
            end
         end
         RUN: begin
            if (STOP) begin
               state_n = PAUSE;
            end else if (presc == LAST) begin
               presc_n = '0;
               hb_n    = ~hb;
               unique case (mode_q)
                  2'b00: pat_n = ~pat;
                  2'b01: pat_n = {pat[2:0], pat[3]};
                  2'b10: begin
                     if (!dir_dn) begin
                        if (pat[3]) begin
                           dir_dn_n = 1'b1;
                           pat_n    = pat >> 1;
                        end else begin
                           pat_n = pat << 1;
                        end
                     end else begin
                        if (pat[0]) begin
                           dir_dn_n = 1'b0;
                           pat_n    = pat << 1;
                        end else begin
                           pat_n = pat >> 1;
                        end
                     end
                  end
                  default: pat_n = pat + 4'd1;
               endcase
            end else begin
               presc_n = presc + PW'(1);
            end
         end
         PAUSE: begin
            if (STOP) begin
               state_n  = IDLE;
               presc_n  = '0;
               pat_n    = 4'b0000;
               dir_dn_n = 1'b0;
               hb_n     = 1'b0;
            end else if (START) begin
               state_n = RUN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state  <= IDLE;
         presc  <= '0;
         pat    <= 4'b0000;
         dir_dn <= 1'b0;
         hb     <= 1'b0;
         mode_q <= 2'b00;
         busy_q <= 1'b0;
      end else begin
         state  <= state_n;
         presc  <= presc_n;
         pat    <= pat_n;
         dir_dn <= dir_dn_n;
         hb     <= hb_n;
         mode_q <= mode_n;
         busy_q <= (state_n != IDLE);
      end
   end

   assign BUSY = busy_q;
   assign LED1 = pat[0];
   assign LED2 = pat[1];
   assign LED3 = pat[2];
   assign LED4 = pat[3];
   assign LED5 = hb;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: step-count model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_led_sequencer;

   localparam int TD = 4;

   logic       SYS_CLK = 1'b0;
   logic       RST = 1'b1;
   logic [1:0] MODE = 2'b00;
   logic       START = 1'b0;
   logic       STOP = 1'b0;
   logic       BUSY, LED1, LED2, LED3, LED4, LED5;

   led_sequencer #(.TICK_DIV(TD)) dut (
      .SYS_CLK(SYS_CLK), .RST(RST), .MODE(MODE), .START(START), .STOP(STOP),
      .BUSY(BUSY), .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int   cyc = 0;
   int   base = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   en = 1'b0;
   logic [5:0] cmp_e, cmp_a, lit_a;

   always @(posedge SYS_CLK) cyc <= cyc + 1;

   // Model: activity state, phase within a step, and number of steps taken
   int         m_st = 0;
   int         m_ph = 0;
   int         m_k = 0;
   logic [1:0] m_mode = 2'b00;

   always @(posedge SYS_CLK) begin
      if (RST) begin
         m_st <= 0; m_ph <= 0; m_k <= 0;
      end else begin
         case (m_st)
            0: if (START && !STOP) begin
                  m_st <= 1; m_mode <= MODE; m_ph <= 0; m_k <= 0;
               end
            1: if (STOP) m_st <= 2;
               else if (m_ph == TD - 1) begin m_ph <= 0; m_k <= m_k + 1; end
               else m_ph <= m_ph + 1;
            default: if (STOP) begin m_st <= 0; m_ph <= 0; m_k <= 0; end
                     else if (START) m_st <= 1;
         endcase
      end
   end

   // {BUSY, LED5, LED4..LED1} as a function of the number of steps taken
   function automatic logic [5:0] expect_out(int st, int k, logic [1:0] md);
      logic [3:0] p;
      if (st == 0) return 6'b0;
      case (md)
         2'b00: p = (k % 2 == 1) ? 4'hF : 4'h0;
         2'b01: p = 4'(1 << (k % 4));
         2'b10: case (k % 6)
                   0: p = 4'b0001;
                   1: p = 4'b0010;
                   2: p = 4'b0100;
                   3: p = 4'b1000;
                   4: p = 4'b0100;
                   default: p = 4'b0010;
                endcase
         default: p = 4'(k % 16);
      endcase
      return {1'b1, 1'(k % 2), p};
   endfunction

   always @(negedge SYS_CLK) begin
      if (en) begin
         cmp_e = expect_out(m_st, m_k, m_mode);
         cmp_a = {BUSY, LED5, LED4, LED3, LED2, LED1};
         n_cmp++;
         if (cmp_a !== cmp_e) begin
            n_bad++;
            $display("FAIL model @%0d: got %b want %b", cyc - base, cmp_a, cmp_e);
         end
      end
   end

   task automatic at(int r);
      while (cyc < base + r) begin
         @(posedge SYS_CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge SYS_CLK); #1;
      RST = 1'b1; START = 1'b0; STOP = 1'b0;
      @(posedge SYS_CLK); #1;
      @(posedge SYS_CLK); #1;
      RST = 1'b0;
      base = cyc;
      en = 1'b1;
   endtask

   task automatic pulse_start(int r, logic [1:0] md);
      at(r); MODE = md; START = 1'b1;
      at(r + 1); START = 1'b0;
   endtask

   task automatic pulse_stop(int r);
      at(r); STOP = 1'b1;
      at(r + 1); STOP = 1'b0;
   endtask

   task automatic lit(int r, logic [5:0] e, string nm);
      at(r);
      @(negedge SYS_CLK);
      lit_a = {BUSY, LED5, LED4, LED3, LED2, LED1};
      n_cmp++;
      if (lit_a !== e) begin
         n_bad++;
         $display("FAIL %s @%0d: got %b want %b", nm, r, lit_a, e);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // reset and idle
      do_reset();
      lit(0, 6'b00_0000, "reset0");
      lit(20, 6'b00_0000, "reset20");

      // chase
      do_reset();
      pulse_start(0, 2'b01);
      lit(1,  6'b10_0001, "chase1");
      lit(5,  6'b11_0010, "chase5");
      lit(9,  6'b10_0100, "chase9");
      lit(13, 6'b11_1000, "chase13");
      lit(17, 6'b10_0001, "chase17");

      // bounce
      do_reset();
      pulse_start(0, 2'b10);
      lit(1,  6'b10_0001, "bounce1");
      lit(5,  6'b11_0010, "bounce5");
      lit(9,  6'b10_0100, "bounce9");
      lit(13, 6'b11_1000, "bounce13");
      lit(17, 6'b10_0100, "bounce17");
      lit(21, 6'b11_0010, "bounce21");
      lit(25, 6'b10_0001, "bounce25");
      lit(29, 6'b11_0010, "bounce29");

      // binary, with MODE changed mid-run
      do_reset();
      pulse_start(0, 2'b11);
      lit(5, 6'b11_0001, "bin5");
      at(30); MODE = 2'b01;
      lit(61, 6'b11_1111, "bin61");
      lit(65, 6'b10_0000, "bin65");
      lit(69, 6'b11_0001, "bin69");

      // blink
      do_reset();
      pulse_start(0, 2'b00);
      lit(1, 6'b10_0000, "blink1");
      lit(5, 6'b11_1111, "blink5");
      lit(9, 6'b10_0000, "blink9");

      // pause / resume
      do_reset();
      pulse_start(0, 2'b01);
      pulse_stop(7);
      lit(8,  6'b11_0010, "pause8");
      lit(20, 6'b11_0010, "pause20");
      pulse_start(20, 2'b00);
      lit(22, 6'b11_0010, "resume22");
      lit(23, 6'b10_0100, "resume23");
      lit(27, 6'b11_1000, "resume27");

      // priority, clear, and reset mid-run
      do_reset();
      pulse_start(0, 2'b01);
      at(6); START = 1'b1; STOP = 1'b1;
      at(7); START = 1'b0; STOP = 1'b0;
      lit(8,  6'b11_0010, "prio8");
      lit(10, 6'b11_0010, "prio10");
      pulse_stop(10);
      lit(11, 6'b00_0000, "clear11");
      pulse_start(14, 2'b01);
      lit(15, 6'b10_0001, "restart15");
      lit(22, 6'b11_0010, "restart22");
      at(22); RST = 1'b1;
      at(23); RST = 1'b0;
      lit(23, 6'b00_0000, "rst23");
      lit(30, 6'b00_0000, "rst30");

      @(posedge SYS_CLK); #1;
      en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Pattern scheduler for the IceStick's five on-board LEDs. A prescaler derived from SYS_CLK produces a pattern step tick. A three-state controller (IDLE/RUN/PAUSE) sequences one of four selectable patterns onto LED1–LED4 and drives a heartbeat on LED5. The block replaces free-running counter-bit LED drive in top-level designs that need start/stop control and multiple display modes.

## Interface
- TICK_DIV, default 6_000_000: SYS_CLK cycles per pattern step (0.5 s at 12 MHz); legal range ≥ 2; prescaler width = $clog2(TICK_DIV).
- SYS_CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- MODE  in  2  pattern select; sampled only on the IDLE→RUN transition.
- START  in  1  start (from IDLE) or resume (from PAUSE); level, sampled each cycle.
- STOP  in  1  pause (from RUN) or clear (from PAUSE); level, sampled each cycle.
- BUSY  out  1  high when state ≠ IDLE.
- LED1..LED4  out  1 each  pattern bits P[0]..P[3].
- LED5  out  1  heartbeat.

## Operation
- States:
  - IDLE: prescaler = 0, P = 0, LED5 = 0.
  - RUN: prescaler counts; pattern advances on each tick.
  - PAUSE: prescaler, P, direction bit and LED5 all held.
- Transitions; STOP has priority over START in every state:
  - IDLE + START → RUN. Latches MODE into mode_q and loads the initial pattern.
  - RUN + STOP → PAUSE.
  - PAUSE + STOP → IDLE.
  - PAUSE + START (STOP low) → RUN. Resumes with the held prescaler and pattern.
  - START in RUN is ignored. STOP in IDLE is ignored.
- Prescaler, RUN only:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - Tick = (prescaler == TICK_DIV-1) while in RUN and STOP low.
  - On the edge where STOP is sampled, neither the prescaler nor P advances.
- Pattern per tick, by mode_q:
  - 00 blink: init 0000; P <= ~P.
  - 01 chase: init 0001; rotate left, 1000 → 0001.
  - 10 bounce: init 0001, dir = up. Shift left while up; at 1000 set dir = down and shift right; at 0001 set dir = up.
  - 10 bounce sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010…
  - 11 binary: init 0000; P <= P + 1 mod 16; 1111 wraps to 0000.
- LED5 toggles on every tick and is cleared in IDLE.
- MODE changes during RUN/PAUSE have no effect until the next IDLE→RUN.
- All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- Reset: one cycle of RST high gives state = IDLE, prescaler = 0, P = 0, dir = up, LED1..LED5 = 0 and BUSY = 0, visible on the next cycle.
- RST overrides all inputs, including mid-RUN or mid-PAUSE.
- START sampled at cycle N in IDLE:
  - BUSY = 1 and the initial pattern are visible at N+1.
  - The prescaler is 0 at N+1.
  - The first update is visible at N+TICK_DIV+1, then every TICK_DIV cycles.
- STOP sampled at cycle M in RUN: outputs frozen from M+1 (BUSY stays 1).
- Resume: START sampled at cycle R in PAUSE with held prescaler value k gives the next update visible at R+1+(TICK_DIV-1-k)+1.
- STOP sampled in PAUSE: LEDs = 0 and BUSY = 0 at the next cycle.

## Test plan
All scenarios use TICK_DIV=4, with START pulsed for one cycle at cycle 0 unless stated.
- Reset: RST high for 2 cycles, then 20 idle cycles → LED1..LED5 = 0 and BUSY = 0 throughout.
- Chase (MODE=01):
  - LED4..LED1 = 0001@1, 0010@5, 0100@9, 1000@13, 0001@17.
  - LED5 = 1@5, 0@9.
  - BUSY = 1 from cycle 1.
- Bounce (MODE=10): updates at 5, 9, 13… read 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Binary (MODE=11) over 17 ticks:
  - Reads 0001..1111, then 0000@65, 0001@69.
  - Toggling MODE at cycle 30 has no effect.
- Pause/resume (chase):
  - STOP@7 gives 0010 frozen from cycle 8, with the prescaler held at 2.
  - START@20 gives 0100 visible @23, then 1000@27.
- Priority and reset (chase):
  - START+STOP both high @6 in RUN → PAUSE.
  - STOP@10 → LEDs 0 and BUSY 0 @11.
  - Restart; RST@8 in RUN → all outputs 0 @9, and IDLE holds while START is low.
